ysyx_24100029_axi_arbiter: RTL
==============================

# ysyx_24100029_axi_arbiter

Two-master to one-slave AXI4 arbiter sharing the core's single external AXI4 master port between the IFU (read-only, master 0) and the LSU (read/write, master 1). It sits between the IFU/LSU bus ports and the SoC interconnect. It holds one outstanding transaction at a time, routes responses back to the granted master, and guarantees no request is ever forwarded without a grant.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- ID_W, 4, AXI ID width, passed through unchanged

Ports:
- clock  in  1  single clock; all logic rises on posedge
- reset  in  1  synchronous, active-high
- m0_arvalid/m0_arready  in/out  1/1  IFU read-address handshake
- m0_araddr/arid/arlen/arsize/arburst  in  ADDR_W/ID_W/8/3/2  IFU read-address payload
- m0_rvalid/m0_rready  out/in  1/1  IFU read-data handshake
- m0_rdata/rresp/rlast/rid  out  DATA_W/2/1/ID_W  IFU read-data payload
- m1_ar*, m1_r*  same set and widths as m0  LSU read channels
- m1_awvalid/m1_awready  in/out  1/1  LSU write-address handshake
- m1_awaddr/awid/awlen/awsize/awburst  in  ADDR_W/ID_W/8/3/2  LSU write-address payload
- m1_wvalid/m1_wready  in/out  1/1; m1_wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1
- m1_bvalid/m1_bready  out/in  1/1; m1_bresp/bid  out  2/ID_W
- s_ar*, s_r*, s_aw*, s_w*, s_b*  mirror of m1 set, opposite directions  to interconnect

## Operation
- States: IDLE, RD0 (IFU read), RD1 (LSU read), WR1 (LSU write).
- IDLE: decide from m0_arvalid, m1_arvalid, m1_awvalid; next-state registered. All s_*valid, s_rready, s_bready, m*_arready, m1_awready, m1_wready, m*_rvalid, m1_bvalid driven 0.
- Priority in IDLE: m1_awvalid > m1_arvalid > m0_arvalid (fixed). m1 write vs read simultaneous: write wins.
- RD0/RD1: granted master's AR payload, valid and ready connected combinationally to s_ar*; R channel connected to granted master; the other master sees arready=0, rvalid=0, payload don't-care.
- AR accepted once per grant: internal ar_done flag set on s_arvalid&s_arready; afterwards s_arvalid forced 0 and m_arready 0.
- RD exits to IDLE on s_rvalid & s_rready & s_rlast.
- WR1: s_aw* and s_w* connected to m1; AW and W may complete in either order (aw_done, w_done flags; W done on wvalid&wready&wlast); s_bready = m1_bready. Exit to IDLE on s_bvalid & s_bready.
- rresp/bresp/rid/bid passed through unmodified; no error handling in the arbiter.
- Write channels of master 0 do not exist; s_aw*/s_w* held 0 outside WR1.

## Timing
- Reset: state=IDLE, ar_done=aw_done=w_done=0, RR pointer=master 1; all outputs listed above 0.
- Grant latency: request visible in IDLE at cycle N -> s_arvalid/s_awvalid asserted in cycle N+1.
- One mandatory IDLE cycle between transactions; back-to-back single-beat reads cost ≥ 3 cycles each (grant, AR, R with zero-wait slave).
- Request deasserted before grant: arbiter still enters the chosen state; masters must hold valid until ready (AXI rule), so this is a master violation, not handled.
- Multi-beat bursts (arlen>0): grant held until rlast; beat count not checked.
- Reset mid-transaction: return to IDLE next cycle, flags cleared; the interconnect is reset by the same signal.
- Responses never cross masters: R/B routing uses registered state only, never live inputs.

## Configuration
- YSYX_24100029_ARB_RR_EN defined: read arbitration between m0 and m1 is round-robin; 1-bit pointer flips to the other master after each completed read; write still preempts reads in IDLE.
- Not defined: fixed priority as in Operation; pointer logic absent.

## Structure
- Package ysyx_24100029_axi_pkg: state enum (IDLE/RD0/RD1/WR1), AXI burst constants (FIXED/INCR/WRAP), resp codes (OKAY/EXOKAY/SLVERR/DECERR), default ID_W.
- Sub-module ysyx_24100029_arb_grant: two-request grant picker with optional RR pointer (the macro lives here only).

## Test plan
- Solo IFU: m0_arvalid, araddr=0x3000_0000 -> s_arvalid next cycle with same address; rdata=0x0000_0413 returned only on m0_rvalid; m1_rvalid stays 0.
- Simultaneous reads m0 (0x3000_0004) and m1 (0x8000_0010), fixed priority -> m1 served first, m0 next; with RR_EN and two rounds -> order m1, m0, m1, m0.
- LSU write with W before AW (wdata=0xDEAD_BEEF, wstrb=0xF, awaddr=0x0F00_0000) -> both handshakes complete, bresp=OKAY on m1_bvalid, state back to IDLE one cycle after b.
- IFU read pending while LSU write in WR1 -> m0_arready held 0 until write B done, then m0 granted after one IDLE cycle.
- 4-beat LSU read (arlen=3) -> grant held across all beats, exits only on rlast; m0 request waits.
- Reset asserted during RD1 after AR accepted -> next cycle all valids 0, state IDLE; fresh m0 request then granted normally.

Source files
------------

// File: rtl/ysyx_24100029_axi_pkg.sv
// Shared types and AXI encodings for the IFU/LSU to SoC AXI4 arbiter.
package ysyx_24100029_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } arb_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int DEFAULT_ID_W = 4;

endpackage

// File: rtl/ysyx_24100029_arb_grant.sv
// Picks which master gets the next read grant. With YSYX_24100029_ARB_RR_EN defined a
// 1-bit round-robin pointer is used; otherwise master 1 has fixed priority.
module ysyx_24100029_arb_grant
    import ysyx_24100029_axi_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic rd_done,
    input  logic rd_done_m1,
    output logic gnt_m1
);

`ifdef YSYX_24100029_ARB_RR_EN
    // Pointer names the master preferred when both request; starts at master 1.
    logic ptr_q, ptr_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ptr_d = ptr_q;
        if (rd_done) ptr_d = ~rd_done_m1;
    end

    // NOTE: sequential state uses <= so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) ptr_q <= 1'b1;
        else       ptr_q <= ptr_d;
    end

    always_comb begin
        gnt_m1 = ptr_q;
        if (req1 && !req0)      gnt_m1 = 1'b1;
        else if (req0 && !req1) gnt_m1 = 1'b0;
    end
`else
    assign gnt_m1 = req1;

    logic unused_rr;
    assign unused_rr = &{1'b0, clock, reset, req0, rd_done, rd_done_m1};
`endif

endmodule

// File: rtl/ysyx_24100029_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter, one transaction
// in flight. Read arbitration mode is selected by YSYX_24100029_ARB_RR_EN (see arb_grant).
module ysyx_24100029_axi_arbiter
    import ysyx_24100029_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = DEFAULT_ID_W
) (
    input  logic                clock,
    input  logic                reset,
    // IFU read
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    output logic [ID_W-1:0]     m0_rid,
    // LSU read
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    output logic [ID_W-1:0]     m1_rid,
    // LSU write
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,
    output logic [ID_W-1:0]     m1_bid,
    // Interconnect side
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [ID_W-1:0]     s_arid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic [ID_W-1:0]     s_rid,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [ID_W-1:0]     s_awid,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp,
    input  logic [ID_W-1:0]     s_bid
);

    arb_state_e state_q, state_d;
    logic ar_done_q, ar_done_d;
    logic aw_done_q, aw_done_d;
    logic w_done_q,  w_done_d;
    logic gnt_m1;

    // All routing decodes from the registered state, never from live requests.
    logic in_rd, in_wr, rd_sel_m1, rd_last, b_hs;
    assign in_rd     = (state_q == RD0) || (state_q == RD1);
    assign in_wr     = (state_q == WR1);
    assign rd_sel_m1 = (state_q == RD1);
    assign rd_last   = in_rd && s_rvalid && s_rready && s_rlast;
    assign b_hs      = in_wr && s_bvalid && s_bready;

    ysyx_24100029_arb_grant u_grant (
        .clock      (clock),
        .reset      (reset),
        .req0       (m0_arvalid),
        .req1       (m1_arvalid),
        .rd_done    (rd_last),
        .rd_done_m1 (rd_sel_m1),
        .gnt_m1     (gnt_m1)
    );

    always_comb begin
        state_d   = state_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (m1_awvalid)                   state_d = WR1;
                else if (m0_arvalid || m1_arvalid) state_d = gnt_m1 ? RD1 : RD0;
            end
            RD0, RD1: begin
                if (s_arvalid && s_arready) ar_done_d = 1'b1;
                if (rd_last) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            WR1: begin
                if (s_awvalid && s_awready)          aw_done_d = 1'b1;
                if (s_wvalid && s_wready && s_wlast) w_done_d  = 1'b1;
                if (b_hs) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Read address: one acceptance per grant
    assign s_arvalid  = in_rd && !ar_done_q && (rd_sel_m1 ? m1_arvalid : m0_arvalid);
    assign s_araddr   = rd_sel_m1 ? m1_araddr  : m0_araddr;
    assign s_arid     = rd_sel_m1 ? m1_arid    : m0_arid;
    assign s_arlen    = rd_sel_m1 ? m1_arlen   : m0_arlen;
    assign s_arsize   = rd_sel_m1 ? m1_arsize  : m0_arsize;
    assign s_arburst  = rd_sel_m1 ? m1_arburst : m0_arburst;
    assign m0_arready = (state_q == RD0) && !ar_done_q && s_arready;
    assign m1_arready = (state_q == RD1) && !ar_done_q && s_arready;

    assign s_rready  = in_rd && (rd_sel_m1 ? m1_rready : m0_rready);
    assign m0_rvalid = (state_q == RD0) && s_rvalid;
    assign m1_rvalid = (state_q == RD1) && s_rvalid;
    assign m0_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m0_rid    = s_rid;
    assign m1_rdata  = s_rdata;
    assign m1_rresp  = s_rresp;
    assign m1_rlast  = s_rlast;
    assign m1_rid    = s_rid;

    // Write channels are only ever driven while the LSU holds the write grant
    assign s_awvalid  = in_wr && !aw_done_q && m1_awvalid;
    assign s_awaddr   = in_wr ? m1_awaddr  : '0;
    assign s_awid     = in_wr ? m1_awid    : '0;
    assign s_awlen    = in_wr ? m1_awlen   : '0;
    assign s_awsize   = in_wr ? m1_awsize  : '0;
    assign s_awburst  = in_wr ? m1_awburst : '0;
    assign m1_awready = in_wr && !aw_done_q && s_awready;

    assign s_wvalid  = in_wr && !w_done_q && m1_wvalid;
    assign s_wdata   = in_wr ? m1_wdata : '0;
    assign s_wstrb   = in_wr ? m1_wstrb : '0;
    assign s_wlast   = in_wr && m1_wlast;
    assign m1_wready = in_wr && !w_done_q && s_wready;

    assign s_bready  = in_wr && m1_bready;
    assign m1_bvalid = in_wr && s_bvalid;
    assign m1_bresp  = s_bresp;
    assign m1_bid    = s_bid;

endmodule
